// File: rtl/fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_stage_ctrl
// Fetch-side producer for the Fetch/Decode pipeline register. Owns the PC,
// issues one instruction-memory request at a time (req/gnt/rvalid), and
// presents each returned instruction with its PC and PC+4 on the _f outputs.
// Honours stall_f from the hazard unit and redirects on pc_src_e.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets park the block in ERR and raise
//               the sticky fetch_misalign_f output until reset.
//   undefined : pc_target_e[1:0] is forced to 0; fetch_misalign_f is absent.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   stall_f           hold the presented instruction
//   pc_src_e          taken branch/jump redirect (single-cycle pulse)
//   pc_target_e       redirect target
//   imem_req/addr     request to instruction memory (addr = pc_q)
//   imem_gnt          request accepted
//   imem_rvalid/rdata response
//   instr_valid_f, instr_rd_f, pc_f, pc_plus4_f
//                     registered Fetch/Decode payload, all zero when invalid
//   fetch_misalign_f  sticky misaligned-target error (macro only)
// ---------------------------------------------------------------------------
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_f,
   input  logic        pc_src_e,
   input  logic [31:0] pc_target_e,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid_f,
   output logic [31:0] instr_rd_f,
   output logic [31:0] pc_f,
   output logic [31:0] pc_plus4_f
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        fetch_misalign_f
`endif
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned SW   = 3;

   localparam logic [SW-1:0] S_IDLE    = 3'd0;
   localparam logic [SW-1:0] S_REQ     = 3'd1;
   localparam logic [SW-1:0] S_WAIT    = 3'd2;
   localparam logic [SW-1:0] S_PRESENT = 3'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [SW-1:0] S_ERR     = 3'd4;
`endif

   logic [SW-1:0]   state_q,  state_d;
   logic [XLEN-1:0] pc_q,     pc_d;
   logic            drop_q,   drop_d;
   logic [XLEN-1:0] redir_q,  redir_d;
   logic            req_d;
   logic            valid_d;
   logic [XLEN-1:0] instr_d,  pcf_d, pcp4_d;
   logic [XLEN-1:0] target_c;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic            pend_q,   pend_d;
   logic            misalign_d;
   logic            target_mis_c;
`endif

   // Redirect target as seen by the PC logic
`ifdef FETCH_MISALIGN_CHECK_EN
   assign target_c     = pc_target_e;
   assign target_mis_c = (pc_target_e[1:0] != 2'b00);
`else
   assign target_c     = pc_target_e & ~XLEN'(3);
`endif

   // Request address is the next fetch PC; it cannot move while in REQ/WAIT
   assign imem_addr = pc_q;

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      redir_d = redir_q;
      valid_d = instr_valid_f;
      instr_d = instr_rd_f;
      pcf_d   = pc_f;
      pcp4_d  = pc_plus4_f;
`ifdef FETCH_MISALIGN_CHECK_EN
      pend_d     = pend_q;
      misalign_d = fetch_misalign_f;
`endif

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (pc_src_e) pc_d = target_c;
         end

         S_REQ: begin
            // Request already on the bus: let it complete, drop its data later
            if (pc_src_e) begin
               redir_d = target_c;
               drop_d  = 1'b1;
            end
            if (imem_gnt) state_d = S_WAIT;
         end

         S_WAIT: begin
            if (imem_rvalid) begin
               if (pc_src_e) begin
                  pc_d    = target_c;
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else if (drop_q) begin
                  pc_d    = redir_q;
                  drop_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  valid_d = 1'b1;
                  instr_d = imem_rdata;
                  pcf_d   = pc_q;
                  pcp4_d  = pc_q + XLEN'(4);
                  state_d = S_PRESENT;
               end
            end else if (pc_src_e) begin
               redir_d = target_c;
               drop_d  = 1'b1;
            end
         end

         S_PRESENT: begin
            if (pc_src_e) begin
               valid_d = 1'b0;
               instr_d = '0;
               pcf_d   = '0;
               pcp4_d  = '0;
               pc_d    = target_c;
               state_d = S_REQ;
            end else if (!stall_f) begin
               valid_d = 1'b0;
               instr_d = '0;
               pcf_d   = '0;
               pcp4_d  = '0;
               pc_d    = pc_f + XLEN'(4);
               state_d = S_REQ;
            end
         end

`ifdef FETCH_MISALIGN_CHECK_EN
         S_ERR: state_d = S_ERR;
`endif

         default: state_d = S_IDLE;
      endcase

`ifdef FETCH_MISALIGN_CHECK_EN
      if (pc_src_e && target_mis_c && (state_q != S_ERR)) pend_d = 1'b1;
      // Park in ERR only once no request is on the bus or in flight
      if (pend_d && (state_q != S_ERR) && (state_q != S_REQ) && (state_d != S_WAIT)) begin
         state_d    = S_ERR;
         valid_d    = 1'b0;
         instr_d    = '0;
         pcf_d      = '0;
         pcp4_d     = '0;
         drop_d     = 1'b0;
         misalign_d = 1'b1;
      end
`endif

      req_d = (state_d == S_REQ);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         pc_q          <= RESET_PC;
         drop_q        <= 1'b0;
         redir_q       <= '0;
         imem_req      <= 1'b0;
         instr_valid_f <= 1'b0;
         instr_rd_f    <= '0;
         pc_f          <= '0;
         pc_plus4_f    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
         pend_q           <= 1'b0;
         fetch_misalign_f <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         drop_q        <= drop_d;
         redir_q       <= redir_d;
         imem_req      <= req_d;
         instr_valid_f <= valid_d;
         instr_rd_f    <= instr_d;
         pc_f          <= pcf_d;
         pc_plus4_f    <= pcp4_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         pend_q           <= pend_d;
         fetch_misalign_f <= misalign_d;
`endif
      end
   end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage_ctrl
// Directed bench for fetch_stage_ctrl with RESET_PC = 0x100. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_f;
   logic        pc_src_e;
   logic [31:0] pc_target_e;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid_f;
   logic [31:0] instr_rd_f;
   logic [31:0] pc_f;
   logic [31:0] pc_plus4_f;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misalign_f;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_stage_ctrl #(.RESET_PC(32'h0000_0100)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_f       (stall_f),
      .pc_src_e      (pc_src_e),
      .pc_target_e   (pc_target_e),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid_f (instr_valid_f),
      .instr_rd_f    (instr_rd_f),
      .pc_f          (pc_f),
      .pc_plus4_f    (pc_plus4_f)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misalign_f (fetch_misalign_f)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive(input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic src, input logic [31:0] tgt, input logic stl);
      imem_gnt    = gnt;
      imem_rvalid = rv;
      imem_rdata  = rd;
      pc_src_e    = src;
      pc_target_e = tgt;
      stall_f     = stl;
   endtask

   task automatic check_f(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
      logic [31:0] p4;
      p4 = v ? pc + 32'd4 : 32'd0;
      check_eq({tag, ".valid"}, 32'(instr_valid_f), 32'(v));
      check_eq({tag, ".instr"}, instr_rd_f, ins);
      check_eq({tag, ".pc"},    pc_f, pc);
      check_eq({tag, ".pc4"},   pc_plus4_f, p4);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      repeat (2) step();
      check_eq("rst.req",  32'(imem_req), 32'd0);
      check_eq("rst.addr", imem_addr, 32'h100);
      check_f("rst", 1'b0, 32'h0, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check_eq("rst.mis", 32'(fetch_misalign_f), 32'd0);
`endif
      rst_n = 1'b1;

      // First fetch at RESET_PC, immediate grant, rvalid one cycle later
      step();
      check_eq("f0.req",  32'(imem_req), 32'd1);
      check_eq("f0.addr", imem_addr, 32'h100);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      check_eq("f0.wait_req", 32'(imem_req), 32'd0);
      drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
      step();
      check_f("f0.pres", 1'b1, 32'h0050_0093, 32'h100);
      check_eq("f0.pres_req", 32'(imem_req), 32'd0);

      // Stall four cycles in PRESENT
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check_f("stall", 1'b1, 32'h0050_0093, 32'h100);
         check_eq("stall.req", 32'(imem_req), 32'd0);
      end
      stall_f = 1'b0;
      step();
      check_eq("rel.req",  32'(imem_req), 32'd1);
      check_eq("rel.addr", imem_addr, 32'h104);
      check_f("rel", 1'b0, 32'h0, 32'h0);

      // Grant withheld for three cycles: address holds
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("nognt.req",  32'(imem_req), 32'd1);
         check_eq("nognt.addr", imem_addr, 32'h104);
      end
      imem_gnt = 1'b1;
      step();
      check_eq("g1.wait_req", 32'(imem_req), 32'd0);

      // Redirect to 0x200 while waiting: response must be discarded
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
      step();
      check_eq("wr.req", 32'(imem_req), 32'd0);
      check_f("wr", 1'b0, 32'h0, 32'h0);
      drive(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
      step();
      check_f("drop", 1'b0, 32'h0, 32'h0);
      check_eq("drop.req",  32'(imem_req), 32'd1);
      check_eq("drop.addr", imem_addr, 32'h200);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
      step();
      check_f("f200", 1'b1, 32'h0000_0013, 32'h200);

      // Redirect from PRESENT to the top word; PC+4 wraps to 0
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      step();
      check_f("top.inv", 1'b0, 32'h0, 32'h0);
      check_eq("top.addr", imem_addr, 32'hFFFF_FFFC);
      check_eq("top.req",  32'(imem_req), 32'd1);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
      step();
      check_f("top", 1'b1, 32'h1111_1111, 32'hFFFF_FFFC);
      check_eq("top.pc4_wrap", pc_plus4_f, 32'h0);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      check_eq("wrap.addr", imem_addr, 32'h0);
      check_eq("wrap.req",  32'(imem_req), 32'd1);

      // Redirect in the same cycle as rvalid: data dropped, target used
      imem_gnt = 1'b1;
      step();
      drive(1'b0, 1'b1, 32'h2222_2222, 1'b1, 32'h300, 1'b0);
      step();
      check_f("same", 1'b0, 32'h0, 32'h0);
      check_eq("same.addr", imem_addr, 32'h300);
      check_eq("same.req",  32'(imem_req), 32'd1);

      // Stray rvalid while in REQ is ignored
      drive(1'b0, 1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
      step();
      check_f("stray", 1'b0, 32'h0, 32'h0);
      check_eq("stray.req",  32'(imem_req), 32'd1);
      check_eq("stray.addr", imem_addr, 32'h300);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b0, 1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b0);
      step();
      check_f("f300", 1'b1, 32'h4444_4444, 32'h300);

      // Misaligned redirect target 0x402
      drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h402, 1'b0);
      step();
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_MISALIGN_CHECK_EN
      for (int i = 0; i < 3; i++) begin
         check_eq("err.mis", 32'(fetch_misalign_f), 32'd1);
         check_eq("err.req", 32'(imem_req), 32'd0);
         check_f("err", 1'b0, 32'h0, 32'h0);
         step();
      end
      rst_n = 1'b0;
      step();
      check_eq("err.rst_mis", 32'(fetch_misalign_f), 32'd0);
      rst_n = 1'b1;
`else
      check_eq("mask.addr", imem_addr, 32'h400);
      check_eq("mask.req",  32'(imem_req), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
